// File: rtl/sevenseg_decode_if.sv
// Frame delivery bus between sevenseg_decode and its consumer.
// master drives the frame payload and valid; slave returns ready.
interface sevenseg_decode_if;
  logic        frame_valid;
  logic        frame_ready;
  logic [15:0] frame_value;
  logic [3:0]  frame_blank;
  logic [3:0]  frame_err;
  logic [3:0]  frame_dp;

  modport master (
    output frame_valid,
    output frame_value,
    output frame_blank,
    output frame_err,
    output frame_dp,
    input  frame_ready
  );

  modport slave (
    input  frame_valid,
    input  frame_value,
    input  frame_blank,
    input  frame_err,
    input  frame_dp,
    output frame_ready
  );
endinterface

// File: rtl/sevenseg_decode.sv
// Seven-segment pin-bus capture: sync, stability filter, decode, 4-digit frames.
// Optional DP capture enabled by defining SEVENSEG_DECODE_DP_EN.
module sevenseg_decode #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [11:0]        pins,
  sevenseg_decode_if.master  frame,
  output logic               overrun,
  input  logic               overrun_clr
);

  localparam logic [7:0] ACC_CNT = 8'(STABLE_CYCLES - 1);

  logic [11:0] pins_m;
  logic [11:0] sync1;
  logic [11:0] pin_s;
  logic [11:0] prev;
  logic [7:0]  cnt;

  logic        stable;
  logic        one_hot;
  logic        accept;
  logic        done;
  logic [3:0]  sel;
  logic [1:0]  idx;
  logic [6:0]  seg;
  logic [3:0]  nib;
  logic        blank;
  logic        err;
  logic [3:0]  bit_new;
  logic [3:0]  seen;
  logic [3:0]  seen_nx;

  logic [15:0] stg_val;
  logic [3:0]  stg_blank;
  logic [3:0]  stg_err;
  logic [15:0] nx_val;
  logic [3:0]  nx_blank;
  logic [3:0]  nx_err;

`ifdef SEVENSEG_DECODE_DP_EN
  logic        dp;
  logic [3:0]  stg_dp;
  logic [3:0]  nx_dp;

  // DP is part of the captured word and of the stability check
  always_comb begin
    pins_m = pins;
    dp     = pin_s[2];
  end
`else
  // DP masked before sync so its toggling never disturbs the filter
  always_comb begin
    pins_m = pins & ~12'h004;
  end
`endif

  // two-flop synchronizer for the asynchronous pin bus
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      pin_s <= '0;
    end else begin
      sync1 <= pins_m;
      pin_s <= sync1;
    end
  end

  // stability filter: restart on change, otherwise saturating count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= '0;
      cnt  <= '0;
    end else if (pin_s != prev) begin
      prev <= pin_s;
      cnt  <= '0;
    end else if (cnt != 8'hFF) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign stable = (pin_s == prev) && (cnt == ACC_CNT);
  assign sel    = {pin_s[5], pin_s[7], pin_s[8], pin_s[11]};
  assign seg    = {pin_s[10], pin_s[6], pin_s[3], pin_s[1],
                   pin_s[0], pin_s[9], pin_s[4]};

  // single active digit select to digit index
  always_comb begin
    one_hot = (sel != 4'h0) && ((sel & (sel - 4'd1)) == 4'h0);
    idx     = 2'd0;
    if (one_hot) begin
      unique case (1'b1)
        sel[0]: idx = 2'd0;
        sel[1]: idx = 2'd1;
        sel[2]: idx = 2'd2;
        sel[3]: idx = 2'd3;
      endcase
    end
  end

  assign accept = stable && one_hot;

  // abcdefg pattern back to a hex nibble
  always_comb begin
    nib   = 4'h0;
    blank = 1'b0;
    err   = 1'b0;
    case (seg)
      7'h7E: nib = 4'h0;
      7'h30: nib = 4'h1;
      7'h6D: nib = 4'h2;
      7'h79: nib = 4'h3;
      7'h33: nib = 4'h4;
      7'h5B: nib = 4'h5;
      7'h5F: nib = 4'h6;
      7'h70: nib = 4'h7;
      7'h7F: nib = 4'h8;
      7'h7B: nib = 4'h9;
      7'h77: nib = 4'hA;
      7'h1F: nib = 4'hB;
      7'h4E: nib = 4'hC;
      7'h3D: nib = 4'hD;
      7'h4F: nib = 4'hE;
      7'h47: nib = 4'hF;
      7'h00: blank = 1'b1;
      default: err = 1'b1;
    endcase
  end

  // staging with the accepted digit merged in
  always_comb begin
    bit_new  = 4'b0001 << idx;
    seen_nx  = seen | bit_new;
    nx_val   = stg_val;
    nx_blank = stg_blank;
    nx_err   = stg_err;
    nx_val[{idx, 2'b00} +: 4] = nib;
    nx_blank[idx] = blank;
    nx_err[idx]   = err;
  end

`ifdef SEVENSEG_DECODE_DP_EN
  // DP staging follows the same merge as the other fields
  always_comb begin
    nx_dp      = stg_dp;
    nx_dp[idx] = dp;
  end
`endif

  assign done = accept && (seen_nx == 4'hF);

  // staging, frame registers, handshake and overrun flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen              <= '0;
      stg_val           <= '0;
      stg_blank         <= '0;
      stg_err           <= '0;
      frame.frame_valid <= 1'b0;
      frame.frame_value <= '0;
      frame.frame_blank <= '0;
      frame.frame_err   <= '0;
      overrun           <= 1'b0;
    end else begin
      if (accept) begin
        stg_val   <= nx_val;
        stg_blank <= nx_blank;
        stg_err   <= nx_err;
        seen      <= done ? 4'h0 : seen_nx;
      end
      if (done) begin
        frame.frame_valid <= 1'b1;
        frame.frame_value <= nx_val;
        frame.frame_blank <= nx_blank;
        frame.frame_err   <= nx_err;
      end else if (frame.frame_valid && frame.frame_ready) begin
        frame.frame_valid <= 1'b0;
      end
      if (done && frame.frame_valid && !frame.frame_ready) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end
  end

`ifdef SEVENSEG_DECODE_DP_EN
  // per-digit decimal point staging and frame copy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_dp         <= '0;
      frame.frame_dp <= '0;
    end else begin
      if (accept) stg_dp <= nx_dp;
      if (done) frame.frame_dp <= nx_dp;
    end
  end
`else
  assign frame.frame_dp = 4'h0;
`endif

endmodule

// File: tb/tb_sevenseg_decode.sv
// Testbench for sevenseg_decode: scoreboarded frame checks.
// Covers decode, filter, select rules, overrun and reset.
module tb_sevenseg_decode;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] pins = '0;
  logic        overrun;
  logic        overrun_clr = 1'b0;

  int checks = 0;
  int fails  = 0;

  typedef struct packed {
    logic [15:0] v;
    logic [3:0]  b;
    logic [3:0]  e;
    logic [3:0]  d;
  } frm_t;

  frm_t sb[$];
  frm_t exp_f;
  frm_t got_f;
  bit   ok;

  logic [6:0] segtab [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  sevenseg_decode_if bus ();

  sevenseg_decode #(.STABLE_CYCLES(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pins        (pins),
    .frame       (bus.master),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] enc(input int d, input logic [6:0] s);
    logic [11:0] p;
    p     = '0;
    p[10] = s[6];
    p[6]  = s[5];
    p[3]  = s[4];
    p[1]  = s[3];
    p[0]  = s[2];
    p[9]  = s[1];
    p[4]  = s[0];
    case (d)
      0: p[11] = 1'b1;
      1: p[8]  = 1'b1;
      2: p[7]  = 1'b1;
      default: p[5] = 1'b1;
    endcase
    return p;
  endfunction

  task automatic hold(input logic [11:0] p, input int n);
    pins = p;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus.frame_valid) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic consume();
    bus.frame_ready = 1'b1;
    @(negedge clk);
    bus.frame_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.frame_ready = 1'b0;
    pins = 12'hFFF;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.frame_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_valid got=%b want=0", bus.frame_valid);
    end
    checks++;
    if ({bus.frame_value, bus.frame_blank, bus.frame_err, bus.frame_dp} !== 28'h0) begin
      fails++;
      $display("FAIL reset_frame got=%h/%b/%b/%b want=0", bus.frame_value,
               bus.frame_blank, bus.frame_err, bus.frame_dp);
    end
    checks++;
    if (overrun !== 1'b0) begin
      fails++;
      $display("FAIL reset_overrun got=%b want=0", overrun);
    end
    pins = 12'h000;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.frame_valid !== 1'b0 || overrun !== 1'b0) begin
      fails++;
      $display("FAIL post_reset got=%b/%b want=0/0", bus.frame_valid, overrun);
    end
  endtask

  task automatic test_frame();
    sb.push_back('{v: 16'h3210, b: 4'h0, e: 4'h0, d: 4'h0});
    hold(12'hE4B, 8);
    hold(12'h148, 8);
    hold(12'h4D3, 8);
    hold(12'h47A, 8);
    wait_valid(20, ok);
    exp_f = sb.pop_front();
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL frame_timeout got=0 want=frame_valid");
    end else begin
      got_f = {bus.frame_value, bus.frame_blank, bus.frame_err, bus.frame_dp};
      if (got_f !== exp_f) begin
        fails++;
        $display("FAIL frame_3210 got=%h want=%h", got_f, exp_f);
      end
    end
    checks++;
    if (overrun !== 1'b0) begin
      fails++;
      $display("FAIL frame_overrun got=%b want=0", overrun);
    end
    consume();
    checks++;
    if (bus.frame_valid !== 1'b0) begin
      fails++;
      $display("FAIL frame_consume got=%b want=0", bus.frame_valid);
    end
  endtask

  task automatic test_glitch();
    hold(12'hE4B, 3);
    hold(12'h000, 10);
    hold(enc(1, segtab[1]), 8);
    hold(enc(2, segtab[2]), 8);
    hold(enc(3, segtab[3]), 8);
    checks++;
    if (bus.frame_valid !== 1'b0) begin
      fails++;
      $display("FAIL glitch_accepted got=%b want=0", bus.frame_valid);
    end
  endtask

  task automatic test_blank_multi();
    hold(12'h948, 20);
    checks++;
    if (bus.frame_valid !== 1'b0) begin
      fails++;
      $display("FAIL multi_select got=%b want=0", bus.frame_valid);
    end
    sb.push_back('{v: 16'h3210, b: 4'b0001, e: 4'h0, d: 4'h0});
    hold(12'h800, 8);
    wait_valid(20, ok);
    exp_f = sb.pop_front();
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL blank_timeout got=0 want=frame_valid");
    end else begin
      got_f = {bus.frame_value, bus.frame_blank, bus.frame_err, bus.frame_dp};
      if (got_f !== exp_f) begin
        fails++;
        $display("FAIL blank_frame got=%h want=%h", got_f, exp_f);
      end
    end
    consume();
  endtask

  task automatic test_err();
    sb.push_back('{v: 16'h3210, b: 4'h0, e: 4'b0001, d: 4'h0});
    hold(12'hC00, 8);
    hold(enc(1, segtab[1]), 8);
    hold(enc(2, segtab[2]), 8);
    hold(enc(3, segtab[3]), 8);
    wait_valid(20, ok);
    exp_f = sb.pop_front();
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL err_timeout got=0 want=frame_valid");
    end else begin
      got_f = {bus.frame_value, bus.frame_blank, bus.frame_err, bus.frame_dp};
      if (got_f !== exp_f) begin
        fails++;
        $display("FAIL err_frame got=%h want=%h", got_f, exp_f);
      end
    end
    consume();
  endtask

  task automatic test_dp_mask();
    sb.push_back('{v: 16'hA5C1, b: 4'h0, e: 4'h0, d: 4'h0});
    for (int i = 0; i < 10; i++) begin
      hold(enc(0, segtab[1]) | ((i % 2 == 1) ? 12'h004 : 12'h000), 1);
    end
    hold(enc(1, segtab[12]) | 12'h004, 8);
    hold(enc(2, segtab[5]) | 12'h004, 8);
    hold(enc(3, segtab[10]) | 12'h004, 8);
    wait_valid(20, ok);
    exp_f = sb.pop_front();
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL dp_timeout got=0 want=frame_valid");
    end else begin
      got_f = {bus.frame_value, bus.frame_blank, bus.frame_err, bus.frame_dp};
      if (got_f !== exp_f) begin
        fails++;
        $display("FAIL dp_frame got=%h want=%h", got_f, exp_f);
      end
    end
    consume();
  endtask

  task automatic test_overrun();
    sb.push_back('{v: 16'h3210, b: 4'h0, e: 4'h0, d: 4'h0});
    for (int i = 0; i < 4; i++) hold(enc(i, segtab[i]), 8);
    wait_valid(20, ok);
    exp_f = sb.pop_front();
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL ovr_first_timeout got=0 want=frame_valid");
    end else begin
      got_f = {bus.frame_value, bus.frame_blank, bus.frame_err, bus.frame_dp};
      if (got_f !== exp_f) begin
        fails++;
        $display("FAIL ovr_first got=%h want=%h", got_f, exp_f);
      end
    end
    sb.push_back('{v: 16'h7654, b: 4'h0, e: 4'h0, d: 4'h0});
    for (int i = 0; i < 4; i++) hold(enc(i, segtab[i + 4]), 8);
    exp_f = sb.pop_front();
    got_f = {bus.frame_value, bus.frame_blank, bus.frame_err, bus.frame_dp};
    checks++;
    if (bus.frame_valid !== 1'b1 || got_f !== exp_f) begin
      fails++;
      $display("FAIL ovr_second got=%b/%h want=1/%h", bus.frame_valid, got_f, exp_f);
    end
    checks++;
    if (overrun !== 1'b1) begin
      fails++;
      $display("FAIL ovr_set got=%b want=1", overrun);
    end
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin
      fails++;
      $display("FAIL ovr_clear got=%b want=0", overrun);
    end
    checks++;
    if (bus.frame_valid !== 1'b1) begin
      fails++;
      $display("FAIL ovr_hold_valid got=%b want=1", bus.frame_valid);
    end
    consume();
    checks++;
    if (bus.frame_valid !== 1'b0) begin
      fails++;
      $display("FAIL ovr_ready_fall got=%b want=0", bus.frame_valid);
    end
  endtask

  task automatic test_reset_mid();
    hold(enc(0, segtab[9]), 8);
    hold(enc(1, segtab[8]), 8);
    hold(enc(2, segtab[2]), 3);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.frame_valid !== 1'b0 || bus.frame_value !== 16'h0 || overrun !== 1'b0) begin
      fails++;
      $display("FAIL midrst_during got=%b/%h/%b want=0/0000/0", bus.frame_valid,
               bus.frame_value, overrun);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.frame_valid, bus.frame_value, bus.frame_blank, bus.frame_err} !== 25'h0) begin
      fails++;
      $display("FAIL midrst_after got=%b/%h want=0/0000", bus.frame_valid, bus.frame_value);
    end
    hold(enc(2, segtab[2]), 8);
    hold(enc(3, segtab[3]), 8);
    checks++;
    if (bus.frame_valid !== 1'b0) begin
      fails++;
      $display("FAIL midrst_partial got=%b want=0", bus.frame_valid);
    end
    sb.push_back('{v: 16'h3210, b: 4'h0, e: 4'h0, d: 4'h0});
    hold(enc(0, segtab[0]), 8);
    hold(enc(1, segtab[1]), 8);
    wait_valid(20, ok);
    exp_f = sb.pop_front();
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL midrst_timeout got=0 want=frame_valid");
    end else begin
      got_f = {bus.frame_value, bus.frame_blank, bus.frame_err, bus.frame_dp};
      if (got_f !== exp_f) begin
        fails++;
        $display("FAIL midrst_frame got=%h want=%h", got_f, exp_f);
      end
    end
    consume();
  endtask

  initial begin
    bus.frame_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_frame();
    test_glitch();
    test_blank_multi();
    test_err();
`ifndef SEVENSEG_DECODE_DP_EN
    test_dp_mask();
`endif
    test_overrun();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
